hal_reset_sequencer: RTL and testbench

HAL_RESET_SEQUENCER -- requirements
Module: hal_reset_sequencer

---
 rtl/hal_reset_sequencer.sv | 162 ++++++++++++++++
 tb/tb_hal_reset_sequencer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/hal_reset_sequencer.sv
// -----------------------------------------------------------------------------
// hal_reset_sequencer
//
// Purpose:
//   Generates CHANNELS active-high reset outputs from two sources:
//     - arst_req, an asynchronous reset request that is synchronised to clk.
//     - sw_rst_req, a reset request that is already synchronous to clk.
//   Any request asserts every channel on the same edge. The outputs stay
//   asserted until ASSERT_CYCLES edges have passed with no request. The
//   channels are then released one at a time, lowest index first, with
//   GAP_CYCLES idle edges between releases. ready is high only once every
//   channel has been released.
//
// Ports:
//   clk         in   sole clock; all state updates on the rising edge
//   rst         in   synchronous active-high reset; wins over any request
//   arst_req    in   asynchronous active-high reset request
//   sw_rst_req  in   synchronous active-high reset request (pulse or level)
//   rst_out     out  [CHANNELS] per-channel active-high reset, registered
//   ready       out  high only when every rst_out bit is low, registered
// -----------------------------------------------------------------------------
module hal_reset_sequencer #(
  parameter int CHANNELS      = 4,
  parameter int SYNC_DEPTH    = 2,
  parameter int ASSERT_CYCLES = 16,
  parameter int GAP_CYCLES    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                arst_req,
  input  logic                sw_rst_req,
  output logic [CHANNELS-1:0] rst_out,
  output logic                ready
);

  // The counter must reach both ASSERT_CYCLES-1 and GAP_CYCLES.
  localparam int CNT_MAX = (ASSERT_CYCLES > GAP_CYCLES + 1) ? ASSERT_CYCLES : GAP_CYCLES + 1;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = $clog2(CHANNELS + 1);

  localparam logic [CNT_W-1:0] ASSERT_LAST = CNT_W'(ASSERT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_FIRST   = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_ONE     = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(CHANNELS - 1);

  typedef enum logic [1:0] {
    ST_ASSERT,
    ST_RELEASE,
    ST_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [CHANNELS-1:0]   rst_out_q, rst_out_d;
  logic                  ready_q, ready_d;
  logic [SYNC_DEPTH-1:0] sync_q, sync_d;

  logic areq_s;
  logic request;

  // Synchroniser: stage 0 samples arst_req, the top stage is the clean request.
  assign sync_d  = {sync_q[SYNC_DEPTH-2:0], arst_req};
  assign areq_s  = sync_q[SYNC_DEPTH-1];
  assign request = areq_s | sw_rst_req;

  // NOTE: every variable gets a default before the case statement, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    rst_out_d = rst_out_q;
    ready_d   = ready_q;

    if (request) begin
      // A request in any state reasserts every channel together. In ASSERT it
      // also restarts the count, which stretches the pulse.
      state_d   = ST_ASSERT;
      cnt_d     = '0;
      idx_d     = '0;
      rst_out_d = '1;
      ready_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_ASSERT: begin
          rst_out_d = '1;
          ready_d   = 1'b0;
          if (cnt_q == ASSERT_LAST) begin
            rst_out_d[0] = 1'b0;
            cnt_d        = '0;
            idx_d        = IDX_FIRST;
            if (CHANNELS == 1) begin
              ready_d = 1'b1;
              state_d = ST_DONE;
            end else begin
              state_d = ST_RELEASE;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end

        ST_RELEASE: begin
          if (cnt_q == GAP_LAST) begin
            // A loop compare avoids indexing rst_out with a wider index.
            for (int i = 0; i < CHANNELS; i++) begin
              if (idx_q == IDX_W'(i)) rst_out_d[i] = 1'b0;
            end
            cnt_d = '0;
            idx_d = idx_q + IDX_ONE;
            if (idx_q == IDX_LAST) begin
              ready_d = 1'b1;
              state_d = ST_DONE;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end

        ST_DONE: begin
          rst_out_d = '0;
          ready_d   = 1'b1;
        end

        default: begin
          state_d   = ST_ASSERT;
          cnt_d     = '0;
          idx_d     = '0;
          rst_out_d = '1;
          ready_d   = 1'b0;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the values that existed before this clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_ASSERT;
      cnt_q     <= '0;
      idx_q     <= '0;
      rst_out_q <= '1;
      ready_q   <= 1'b0;
      sync_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      rst_out_q <= rst_out_d;
      ready_q   <= ready_d;
      sync_q    <= sync_d;
    end
  end

  assign rst_out = rst_out_q;
  assign ready   = ready_q;

endmodule

// File: tb/tb_hal_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_hal_reset_sequencer
//
// Three sequencer configurations share one stimulus stream:
//   u_def   : CHANNELS=4, ASSERT_CYCLES=16, GAP_CYCLES=4
//   u_one   : CHANNELS=1, ASSERT_CYCLES=1,  GAP_CYCLES=0
//   u_three : CHANNELS=3, ASSERT_CYCLES=5,  GAP_CYCLES=0
// All three use SYNC_DEPTH=2.
//
// Reference model: n counts edges since the last reset edge. last_req is the
// most recent edge that sampled a request, and a reset counts as a request at
// edge 0. Channel i is released once n >= last_req + A + i*(G+1). ready is
// high once the top channel has been released. An arst_req sampled at edge j
// becomes a request at edge j+SYNC_DEPTH.
// -----------------------------------------------------------------------------
module tb_hal_reset_sequencer;

  localparam int SYNC = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic arst_req = 1'b0;
  logic sw_rst_req = 1'b0;

  logic [3:0] def_rst_out;
  logic       def_ready;
  logic [0:0] one_rst_out;
  logic       one_ready;
  logic [2:0] three_rst_out;
  logic       three_ready;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  // Model state.
  int n = 0;
  int last_req = 0;
  bit arst_hist[$];

  always #5 clk = ~clk;

  hal_reset_sequencer #(.CHANNELS(4), .SYNC_DEPTH(SYNC), .ASSERT_CYCLES(16), .GAP_CYCLES(4)) u_def (
    .clk(clk), .rst(rst), .arst_req(arst_req), .sw_rst_req(sw_rst_req),
    .rst_out(def_rst_out), .ready(def_ready)
  );

  hal_reset_sequencer #(.CHANNELS(1), .SYNC_DEPTH(SYNC), .ASSERT_CYCLES(1), .GAP_CYCLES(0)) u_one (
    .clk(clk), .rst(rst), .arst_req(arst_req), .sw_rst_req(sw_rst_req),
    .rst_out(one_rst_out), .ready(one_ready)
  );

  hal_reset_sequencer #(.CHANNELS(3), .SYNC_DEPTH(SYNC), .ASSERT_CYCLES(5), .GAP_CYCLES(0)) u_three (
    .clk(clk), .rst(rst), .arst_req(arst_req), .sw_rst_req(sw_rst_req),
    .rst_out(three_rst_out), .ready(three_ready)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t edge=%0d: got 0x%0h expected 0x%0h", name, $time, n, act, exp);
    end
  endtask

  function automatic logic [15:0] exp_rst(input int c, input int a, input int g);
    logic [15:0] v;
    v = '0;
    for (int i = 0; i < c; i++) v[i] = !(n >= last_req + a + i * (g + 1));
    return v;
  endfunction

  function automatic logic [15:0] exp_ready(input int c, input int a, input int g);
    return {15'd0, (n >= last_req + a + (c - 1) * (g + 1))};
  endfunction

  // Model update. Inputs are driven 2 time units after each edge, so they are
  // stable when this samples them.
  always @(posedge clk) begin
    bit areq;
    if (rst) begin
      n = 0;
      last_req = 0;
      arst_hist.delete();
    end else begin
      n++;
      arst_hist.push_back(arst_req);
      areq = 1'b0;
      if (arst_hist.size() > SYNC) areq = arst_hist.pop_front();
      if (areq || sw_rst_req) last_req = n;
    end
  end

  // Compare every cycle against the model.
  always @(posedge clk) begin
    #1;
    if (cmp_en) begin
      check("def_rst_out",   {12'd0, def_rst_out},   exp_rst(4, 16, 4));
      check("def_ready",     {15'd0, def_ready},     exp_ready(4, 16, 4));
      check("one_rst_out",   {15'd0, one_rst_out},   exp_rst(1, 1, 0));
      check("one_ready",     {15'd0, one_ready},     exp_ready(1, 1, 0));
      check("three_rst_out", {13'd0, three_rst_out}, exp_rst(3, 5, 0));
      check("three_ready",   {15'd0, three_ready},   exp_ready(3, 5, 0));
    end
  end

  // Advance until the model edge counter reaches t, then settle 2 units.
  task automatic run_to(input int t);
    int guard;
    guard = 0;
    while (n < t && guard < 2000) begin
      @(posedge clk);
      #2;
      guard++;
    end
    if (n < t) begin
      errors++;
      checks++;
      $display("FAIL run_to timeout: edge=%0d target=%0d", n, t);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2;
    cmp_en = 1'b1;
    check("pin_reset_def_rst", {12'd0, def_rst_out}, 16'hF);
    check("pin_reset_def_rdy", {15'd0, def_ready}, 16'h0);

    // Release from reset; edge 1 is the first edge with rst low.
    rst = 1'b0;
    run_to(1);
    check("pin_one_rst_e1", {15'd0, one_rst_out}, 16'h0);
    check("pin_one_rdy_e1", {15'd0, one_ready}, 16'h1);
    run_to(5);  check("pin_three_e5", {13'd0, three_rst_out}, 16'h6);
    run_to(6);  check("pin_three_e6", {13'd0, three_rst_out}, 16'h4);
    run_to(7);  check("pin_three_e7", {13'd0, three_rst_out}, 16'h0);
    check("pin_three_rdy_e7", {15'd0, three_ready}, 16'h1);
    run_to(15); check("pin_def_e15", {12'd0, def_rst_out}, 16'hF);
    run_to(16); check("pin_def_e16", {12'd0, def_rst_out}, 16'hE);
    run_to(21); check("pin_def_e21", {12'd0, def_rst_out}, 16'hC);
    run_to(26); check("pin_def_e26", {12'd0, def_rst_out}, 16'h8);
    run_to(30); check("pin_def_rdy_e30", {15'd0, def_ready}, 16'h0);
    run_to(31); check("pin_def_e31", {12'd0, def_rst_out}, 16'h0);
    check("pin_def_rdy_e31", {15'd0, def_ready}, 16'h1);

    // Stretch: sw pulses sampled at edges 41 and 51, release due at 67.
    run_to(40); sw_rst_req = 1'b1;
    run_to(41); sw_rst_req = 1'b0;
    check("pin_sw_assert", {12'd0, def_rst_out}, 16'hF);
    check("pin_sw_rdy", {15'd0, def_ready}, 16'h0);
    run_to(50); sw_rst_req = 1'b1;
    run_to(51); sw_rst_req = 1'b0;
    run_to(66); check("pin_stretch_e66", {12'd0, def_rst_out}, 16'hF);
    run_to(67); check("pin_stretch_e67", {12'd0, def_rst_out}, 16'hE);
    run_to(82); check("pin_stretch_rdy", {15'd0, def_ready}, 16'h1);

    // Single pulse from DONE at edge 90: release at 106, ready at 121.
    run_to(89); sw_rst_req = 1'b1;
    run_to(90); sw_rst_req = 1'b0;
    run_to(105); check("pin_pulse_e105", {12'd0, def_rst_out}, 16'hF);
    run_to(106); check("pin_pulse_e106", {12'd0, def_rst_out}, 16'hE);

    // arst_req rises before edge 107, so it is seen as a request at edge 109.
    arst_req = 1'b1;
    run_to(107); arst_req = 1'b0;
    run_to(108); check("pin_arst_e108", {12'd0, def_rst_out}, 16'hE);
    run_to(109); check("pin_arst_e109", {12'd0, def_rst_out}, 16'hF);
    run_to(124); check("pin_arst_e124", {12'd0, def_rst_out}, 16'hF);
    run_to(125); check("pin_arst_e125", {12'd0, def_rst_out}, 16'hE);
    run_to(130); check("pin_arst_e130", {12'd0, def_rst_out}, 16'hC);

    // rst together with sw_rst_req mid-RELEASE: rst wins, then a clean restart.
    rst = 1'b1;
    sw_rst_req = 1'b1;
    @(posedge clk); #2;
    check("pin_rst_mid_def", {12'd0, def_rst_out}, 16'hF);
    check("pin_rst_mid_rdy", {15'd0, def_ready}, 16'h0);
    check("pin_rst_mid_one", {15'd0, one_rst_out}, 16'h1);
    sw_rst_req = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
    run_to(15); check("pin_restart_e15", {12'd0, def_rst_out}, 16'hF);
    run_to(16); check("pin_restart_e16", {12'd0, def_rst_out}, 16'hE);
    run_to(31); check("pin_restart_rdy", {15'd0, def_ready}, 16'h1);

    // Randomised phase, checked every cycle by the compare process.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk); #2;
      sw_rst_req = ($urandom_range(0, 99) == 0);
      if (arst_req) arst_req = ($urandom_range(0, 3) != 0);
      else          arst_req = ($urandom_range(0, 59) == 0);
      rst = ($urandom_range(0, 699) == 0);
    end
    @(posedge clk); #2;
    rst = 1'b0;
    sw_rst_req = 1'b0;
    arst_req = 1'b0;
    repeat (40) @(posedge clk);
    #2;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
